// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_pkg;

    localparam int unsigned PC_INC             = 4;
    localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise holds.
module if_id_reg #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc4,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc4,
    output logic              o_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_instr <= NOP_INSTR;
            o_pc4   <= '0;
            o_valid <= 1'b0;
        end else if (i_bubble) begin
            o_instr <= NOP_INSTR;
            o_pc4   <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_pc4   <= i_pc4;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, RUN/HALT control and IF/ID register load.
// Optional FETCH_PERF_EN adds saturating fetch/flush event counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR  = DATA_W'(NOP_INSTR_DEFAULT),
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              IF_ID_flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_load;
    logic              w_bubble;
    logic              r_halted;
    logic              w_unused_tgt_lsb;

    assign w_pc_inc         = r_pc + ADDR_W'(PC_INC);
    assign w_unused_tgt_lsb = ^branch_target[1:0];
    assign imem_addr        = r_pc;
    assign halted           = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == HALT);
        end
    end

    // Priority: branch > flush > stall > normal RUN/HALT behaviour.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        if (branch_taken) begin
            w_pc_nxt    = {branch_target[ADDR_W-1:2], 2'b00};
            w_bubble    = 1'b1;
            w_state_nxt = RUN;
        end else if (IF_ID_flush) begin
            w_bubble = 1'b1;
            if (!stall && (r_state == RUN)) begin
                w_pc_nxt = w_pc_inc;
            end
        end else if (!stall) begin
            if (r_state == RUN) begin
                w_load = 1'b1;
                // The halt word parks the PC on itself.
                if (imem_rdata == HALT_INSTR) begin
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end else begin
                w_bubble = 1'b1;
            end
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_bubble(w_bubble),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc_inc),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (w_load) begin
                perf_fetched <= sat_inc32(perf_fetched);
            end
            if (branch_taken || IF_ID_flush) begin
                perf_flushed <= sat_inc32(perf_flushed);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random stall/branch/flush traffic
// against a behavioural model of the fetch rules (FETCH_PERF_EN also checks counters).
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        IF_ID_flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    logic [31:0] halt_addr;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halt;
    int unsigned m_fetched;
    int unsigned m_flushed;

    logic        rs;
    logic        rb;
    logic        rf;
    logic [31:0] rt;

    always #5 clk = ~clk;

    // Instruction memory contents: one halt location, one fixed word, otherwise address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha);
        if (a == ha) return HALT_W;
        if (a == 32'h0000_0100) return 32'h2008_0005;
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr, halt_addr);

    if_fetch_stage #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP_W),
        .HALT_INSTR(HALT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .IF_ID_flush  (IF_ID_flush),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_bubble();
        m_instr = NOP_W;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_halt    = 1'b0;
        m_fetched = 0;
        m_flushed = 0;
        model_bubble();
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".addr"},   imem_addr,          m_pc);
        check_val({tag, ".instr"},  if_id_instr,        m_instr);
        check_val({tag, ".pc4"},    if_id_pc4,          m_pc4);
        check_val({tag, ".valid"},  32'(if_id_valid),   32'(m_valid));
        check_val({tag, ".halted"}, 32'(halted),        32'(m_halt));
`ifdef FETCH_PERF_EN
        check_val({tag, ".pfetch"}, perf_fetched,       m_fetched);
        check_val({tag, ".pflush"}, perf_flushed,       m_flushed);
`endif
    endtask

    // Drive one clock of inputs, advance the model by the fetch rules, then compare.
    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic f,
                         input string tag);
        logic [31:0] w;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        IF_ID_flush   = f;
        w = mem_word(m_pc, halt_addr);
        if (b || f) m_flushed++;
        if (b) begin
            m_pc   = {t[31:2], 2'b00};
            m_halt = 1'b0;
            model_bubble();
        end else if (f) begin
            model_bubble();
            if (!s && !m_halt) m_pc = m_pc + 32'd4;
        end else if (!s) begin
            if (!m_halt) begin
                m_instr = w;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_fetched++;
                if (w == HALT_W) m_halt = 1'b1;
                else m_pc = m_pc + 32'd4;
            end else begin
                model_bubble();
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        IF_ID_flush   = 1'b0;
        halt_addr     = 32'h0000_0120;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        drive(1'b0, 1'b0, 32'h0, 1'b0, "first");
        check_val("first_instr", if_id_instr, 32'h2008_0005);
        check_val("first_pc4",   if_id_pc4,   32'h0000_0104);
        check_val("first_addr",  imem_addr,   32'h0000_0104);
        drive(1'b0, 1'b0, 32'h0, 1'b0, "seq");

        drive(1'b1, 1'b0, 32'h0, 1'b0, "stall1");
        drive(1'b1, 1'b0, 32'h0, 1'b0, "stall2");
        check_val("stall_addr", imem_addr, 32'h0000_0108);
        drive(1'b0, 1'b0, 32'h0, 1'b0, "resume");
        check_val("resume_addr", imem_addr, 32'h0000_010C);

        drive(1'b1, 1'b1, 32'h0000_0203, 1'b0, "br_stall");
        check_val("br_stall_addr",  imem_addr,          32'h0000_0200);
        check_val("br_stall_valid", 32'(if_id_valid),   32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, "br_next");
        check_val("br_next_instr", if_id_instr, 32'hA7C3_FDFF);
        check_val("br_next_pc4",   if_id_pc4,   32'h0000_0204);

        drive(1'b0, 1'b1, 32'h0000_0118, 1'b0, "br_halt");
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, "to_halt");
        check_val("halt_word",   if_id_instr,      HALT_W);
        check_val("halt_valid",  32'(if_id_valid), 32'h1);
        check_val("halt_flag",   32'(halted),      32'h1);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, "halted");
        check_val("halted_addr",  imem_addr,        32'h0000_0120);
        check_val("halted_valid", 32'(if_id_valid), 32'h0);

        drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, "unhalt");
        check_val("unhalt_flag", 32'(halted), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, "unhalt_fetch");
        check_val("unhalt_pc4", if_id_pc4, 32'h0000_0044);

        drive(1'b0, 1'b0, 32'h0, 1'b1, "flush");
        check_val("flush_addr", imem_addr, 32'h0000_0048);
        halt_addr = 32'h0000_0048;
        drive(1'b0, 1'b1, 32'h0000_0080, 1'b0, "halt_vs_br");
        check_val("halt_vs_br_flag", 32'(halted), 32'h0);

        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "br_wrap");
        drive(1'b0, 1'b0, 32'h0, 1'b0, "wrap");
        check_val("wrap_pc4",  if_id_pc4, 32'h0);
        check_val("wrap_addr", imem_addr, 32'h0);

        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        halt_addr = 32'h0000_1040;
        repeat (400) begin
            rs = ($urandom_range(0, 4) == 0);
            rb = ($urandom_range(0, 9) == 0);
            rf = ($urandom_range(0, 9) == 0);
            rt = 32'h0000_1000 | 32'($urandom_range(0, 255));
            drive(rs, rb, rt, rf, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
